// File: rtl/lea_xor_sched.sv
// lea_xor_sched: sequences the six key-mixing XORs of one LEA round over a
// shared 32-bit block XOR. A job (X0..X3, RK0..RK5, tag) is accepted in IDLE,
// the operands OP0..OP5 are built one per cycle in RUN, and the result is
// held in DONE until the downstream stage takes it.
// Build option: define LEA_XOR_DUAL_EN to use two XOR instances and finish
// RUN in three cycles (two operands per cycle). Results are identical.

module lea_block_xor #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i1,
  input  logic [WORD_W-1:0] i2,
  output logic [WORD_W-1:0] o
);
  assign o = i1 ^ i2;
endmodule

module lea_xor_sched #(
  parameter int WORD_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*WORD_W-1:0]   in_state,
  input  logic [6*WORD_W-1:0]   in_rk,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6*WORD_W-1:0]   out_op,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

`ifdef LEA_XOR_DUAL_EN
  localparam logic [2:0] STEP_INC  = 3'd2;
  localparam logic [2:0] LAST_STEP = 3'd4;
`else
  localparam logic [2:0] STEP_INC  = 3'd1;
  localparam logic [2:0] LAST_STEP = 3'd5;
`endif

  state_t                   state_q, state_d;
  logic [2:0]               step_q;
  logic [3:0][WORD_W-1:0]   x_q;
  logic [5:0][WORD_W-1:0]   rk_q;
  logic [5:0][WORD_W-1:0]   op_q;
  logic [TAG_W-1:0]         tag_q;
  logic                     step_bad;
  logic [2:0]               step_a;
  logic [WORD_W-1:0]        xa_i1, xa_i2, xa_o;

  // Block-word select: steps 0..5 read X0, X1, X1, X2, X2, X3.
  function automatic logic [1:0] xsel(input logic [2:0] s);
    case (s)
      3'd0:       xsel = 2'd0;
      3'd1, 3'd2: xsel = 2'd1;
      3'd3, 3'd4: xsel = 2'd2;
      default:    xsel = 2'd3;
    endcase
  endfunction

  // Steps 6 and 7 are illegal; clamp the index so no read goes out of range.
  assign step_bad = (step_q > 3'd5);
  assign step_a   = step_bad ? 3'd0 : step_q;

  assign xa_i1 = x_q[xsel(step_a)];
  assign xa_i2 = rk_q[step_a];

  lea_block_xor #(.WORD_W(WORD_W)) u_xor_a (.i1(xa_i1), .i2(xa_i2), .o(xa_o));

`ifdef LEA_XOR_DUAL_EN
  logic [2:0]        step_b;
  logic [WORD_W-1:0] xb_i1, xb_i2, xb_o;

  // Second lane always takes the odd step following lane A.
  assign step_b = (step_a == 3'd5) ? 3'd5 : step_a + 3'd1;
  assign xb_i1  = x_q[xsel(step_b)];
  assign xb_i2  = rk_q[step_b];

  lea_block_xor #(.WORD_W(WORD_W)) u_xor_b (.i1(xb_i1), .i2(xb_i2), .o(xb_o));
`endif

  assign in_ready = (state_q == IDLE);
  assign out_op   = op_q;
  assign out_tag  = tag_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; flush overrides both handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN: begin
        if (step_bad)                state_d = IDLE;
        else if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Job capture, operand write-back, step counter and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 3'd0;
      x_q       <= '0;
      rk_q      <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      step_q    <= 3'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q    <= in_state;
            rk_q   <= in_rk;
            tag_q  <= in_tag;
            step_q <= 3'd0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (step_bad) begin
            step_q <= 3'd0;
            busy   <= 1'b0;
          end else begin
            op_q[step_a] <= xa_o;
`ifdef LEA_XOR_DUAL_EN
            op_q[step_b] <= xb_o;
`endif
            if (step_q == LAST_STEP) begin
              step_q    <= 3'd0;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              step_q <= step_q + STEP_INC;
            end
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          step_q    <= 3'd0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lea_xor_sched.sv
// Testbench for lea_xor_sched: directed jobs, expected results queued at
// issue time and compared by an independent output monitor.
module tb_lea_xor_sched;

`ifdef LEA_XOR_DUAL_EN
  localparam int LAT   = 3;
  localparam int FL_AT = 1;
`else
  localparam int LAT   = 6;
  localparam int FL_AT = 3;
`endif

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [191:0] in_rk;
  logic [4:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [191:0] out_op;
  logic [4:0]   out_tag;
  logic         busy;

  lea_xor_sched #(.WORD_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_rk(in_rk), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] X_A  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [191:0] RK_A = {32'h00F00000, 32'h000F0000, 32'h0000F000,
                                   32'h00000F00, 32'h000000F0, 32'h0000000F};
  localparam logic [191:0] OP_A = {32'h44B44444, 32'h333C3333, 32'h3333C333,
                                   32'h22222D22, 32'h222222D2, 32'h1111111E};
  localparam logic [191:0] OP_B = {32'h44444444, 32'h33333333, 32'h33333333,
                                   32'h22222222, 32'h22222222, 32'h11111111};
  localparam logic [191:0] ONES = {6{32'hFFFFFFFF}};

  typedef struct packed {
    logic [191:0] op;
    logic [4:0]   tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total  = 0;
  int passed = 0;
  int pushed = 0;
  int popped = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic push(input logic [191:0] op, input logic [4:0] tag);
    exp_q.push_back({op, tag});
    pushed++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [127:0] s, input logic [191:0] rk, input logic [4:0] tag,
                      input bit hold, output int waited);
    in_state = s;
    in_rk    = rk;
    in_tag   = tag;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("accept_timeout", 192'(0), 192'(1));
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Output monitor: one comparison set per completed transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      popped++;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 192'(out_tag), 192'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("out_op", out_op, mon_e.op);
        check("out_tag", 192'(out_tag), 192'(mon_e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok_op, ok_tag, ok_rdy, ok_vld, rose;
    logic [191:0] hold_op;
    logic [4:0]   hold_tag;

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_state = '0; in_rk = '0; in_tag = '0;
    #1 rst_n = 1'b0;
    #13;
    check("rst_in_ready", 192'(in_ready), 192'(1));
    check("rst_out_valid", 192'(out_valid), 192'(0));
    check("rst_busy", 192'(busy), 192'(0));
    check("rst_out_op", out_op, 192'(0));
    check("rst_out_tag", 192'(out_tag), 192'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic round
    push(OP_A, 5'd7);
    send(X_A, RK_A, 5'd7, 1'b0, n);
    check("basic_busy", 192'(busy), 192'(1));
    check("basic_in_ready_run", 192'(in_ready), 192'(0));
    wait_valid(n);
    check("basic_latency", 192'(n), 192'(LAT));
    @(posedge clk); #1;
    check("basic_valid_drop", 192'(out_valid), 192'(0));
    check("basic_in_ready_back", 192'(in_ready), 192'(1));

    // Backpressure
    out_ready = 1'b0;
    push(OP_A, 5'd7);
    send(X_A, RK_A, 5'd7, 1'b0, n);
    wait_valid(n);
    check("bp_latency", 192'(n), 192'(LAT));
    hold_op = out_op; hold_tag = out_tag;
    ok_op = 1; ok_tag = 1; ok_rdy = 1; ok_vld = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_op !== hold_op) ok_op = 0;
      if (out_tag !== hold_tag) ok_tag = 0;
      if (in_ready !== 1'b0) ok_rdy = 0;
      if (out_valid !== 1'b1) ok_vld = 0;
    end
    check("bp_op_stable", 192'(ok_op), 192'(1));
    check("bp_tag_stable", 192'(ok_tag), 192'(1));
    check("bp_in_ready_low", 192'(ok_rdy), 192'(1));
    check("bp_valid_held", 192'(ok_vld), 192'(1));
    check("bp_op_value", out_op, OP_A);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 192'(out_valid), 192'(0));
    check("bp_release_ready", 192'(in_ready), 192'(1));

    // Back-to-back with in_valid held
    push(OP_A, 5'd7);
    push(OP_B, 5'd8);
    send(X_A, RK_A, 5'd7, 1'b1, n);
    send(X_A, 192'(0), 5'd8, 1'b0, n);
    check("b2b_gap", 192'(n), 192'(LAT + 1));
    wait_valid(n);
    check("b2b_latency", 192'(n), 192'(LAT));
    @(posedge clk); #1;

    // Flush mid-RUN: no expectation queued for this job
    send(X_A, RK_A, 5'd3, 1'b0, n);
    repeat (FL_AT) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 192'(in_ready), 192'(1));
    check("flush_busy", 192'(busy), 192'(0));
    rose = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1;
    end
    check("flush_no_valid", 192'(rose), 192'(0));
    push(OP_A, 5'd4);
    send(X_A, RK_A, 5'd4, 1'b0, n);
    wait_valid(n);
    check("flush_after_latency", 192'(n), 192'(LAT));
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN
    send(X_A, RK_A, 5'd9, 1'b0, n);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 192'(out_valid), 192'(0));
    check("arst_busy", 192'(busy), 192'(0));
    check("arst_in_ready", 192'(in_ready), 192'(1));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity: all-ones key over zero state, then key equal to the selected words
    push(ONES, 5'd10);
    send(128'(0), ONES, 5'd10, 1'b0, n);
    wait_valid(n);
    check("ident1_latency", 192'(n), 192'(LAT));
    @(posedge clk); #1;
    push(192'(0), 5'd31);
    send(X_A, OP_B, 5'd31, 1'b0, n);
    wait_valid(n);
    check("ident2_latency", 192'(n), 192'(LAT));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    check("queue_empty", 192'(exp_q.size()), 192'(0));
    check("xfer_count", 192'(popped), 192'(pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
